counter_nb_fsm: RTL and testbench

//  Parametrised run/done counter: on a start pulse, counts i_num_cnt valid cycles
//  up or down, with pause, abort and auto-repeat.

---
 rtl/counter_nb_fsm.sv | 133 +++++++++++++
 tb/tb_counter_nb_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_nb_fsm.sv
// ----------------------------------------------------------------------------
// counter_nb_fsm
//
// Run/done sequence counter. A start request latches a count length N, a
// direction and an auto-repeat flag, then walks o_cnt through N valid cycles
// (0..N-1 up, or N-1..0 down). Pause holds the count, abort drops straight
// back to IDLE, and repeat reloads the start value at the terminal count with
// no gap cycle. Without repeat, a single-cycle DONE follows the last value.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   i_run        in   start request, honoured only in IDLE with i_num_cnt != 0
//   i_num_cnt    in   count length N, latched on start
//   i_dir        in   0 = count up, 1 = count down, latched on start
//   i_repeat     in   auto-reload at terminal, latched on start
//   i_pause      in   hold o_cnt while running
//   i_abort      in   leave RUN without o_done
//   o_idle       out  state is IDLE
//   o_running    out  state is RUN
//   o_done       out  one-cycle pulse after the final valid count
//   o_cnt        out  current count, 0 outside RUN
//   o_cnt_valid  out  o_cnt is consumed this cycle (RUN and not paused)
//   o_cnt_tc     out  valid cycle carrying the terminal value
// ----------------------------------------------------------------------------
module counter_nb_fsm #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
    input  logic                 i_dir,
    input  logic                 i_repeat,
    input  logic                 i_pause,
    input  logic                 i_abort,
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_cnt_valid,
    output logic                 o_cnt_tc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_num;
    logic                 r_dir;
    logic                 r_repeat;

    logic [1:0]           w_state_d;
    logic [CNT_WIDTH-1:0] w_cnt_d;
    logic [CNT_WIDTH-1:0] w_num_d;
    logic                 w_dir_d;
    logic                 w_repeat_d;
    logic                 w_term;
    logic [CNT_WIDTH-1:0] w_reload;

    // Terminal value depends on the latched direction: N-1 going up, 0 going down.
    assign w_term   = r_dir ? (r_cnt == '0) : (r_cnt == (r_num - 1'b1));
    // Start value used when auto-repeat wraps around.
    assign w_reload = r_dir ? (r_num - 1'b1) : '0;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_num_d    = r_num;
        w_dir_d    = r_dir;
        w_repeat_d = r_repeat;
        case (r_state)
            ST_IDLE: begin
                if (i_run && (i_num_cnt != '0)) begin
                    w_state_d  = ST_RUN;
                    w_num_d    = i_num_cnt;
                    w_dir_d    = i_dir;
                    w_repeat_d = i_repeat;
                    w_cnt_d    = i_dir ? (i_num_cnt - 1'b1) : '0;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (i_pause) begin
                    w_cnt_d = r_cnt;
                end else if (!w_term) begin
                    w_cnt_d = r_dir ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
                end else if (r_repeat) begin
                    w_cnt_d = w_reload;
                end else begin
                    w_state_d = ST_DONE;
                    w_cnt_d   = '0;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_num    <= '0;
            r_dir    <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_num    <= w_num_d;
            r_dir    <= w_dir_d;
            r_repeat <= w_repeat_d;
        end
    end

    assign o_idle      = (r_state == ST_IDLE);
    assign o_running   = (r_state == ST_RUN);
    assign o_done      = (r_state == ST_DONE);
    assign o_cnt       = r_cnt;
    assign o_cnt_valid = o_running && !i_pause;
    assign o_cnt_tc    = o_cnt_valid && w_term;

endmodule

// File: tb/tb_counter_nb_fsm.sv
// ----------------------------------------------------------------------------
// tb_counter_nb_fsm
//
// Directed scenarios followed by random traffic. Expected outputs come from a
// sequence-level model: an active flag, the index of the current step within
// the N-step sequence, and a pending-done flag. The count value is derived
// from the step index and the direction.
// ----------------------------------------------------------------------------
module tb_counter_nb_fsm;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset_n;
    logic         i_run;
    logic [W-1:0] i_num_cnt;
    logic         i_dir;
    logic         i_repeat;
    logic         i_pause;
    logic         i_abort;
    logic         o_idle;
    logic         o_running;
    logic         o_done;
    logic [W-1:0] o_cnt;
    logic         o_cnt_valid;
    logic         o_cnt_tc;

    counter_nb_fsm #(
        .CNT_WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_run       (i_run),
        .i_num_cnt   (i_num_cnt),
        .i_dir       (i_dir),
        .i_repeat    (i_repeat),
        .i_pause     (i_pause),
        .i_abort     (i_abort),
        .o_idle      (o_idle),
        .o_running   (o_running),
        .o_done      (o_done),
        .o_cnt       (o_cnt),
        .o_cnt_valid (o_cnt_valid),
        .o_cnt_tc    (o_cnt_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Sequence-level reference state
    bit m_act;
    bit m_done;
    int m_n;
    int m_pos;
    bit m_dir;
    bit m_rep;
    int done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_done = 1'b0;
        m_n    = 0;
        m_pos  = 0;
        m_dir  = 1'b0;
        m_rep  = 1'b0;
    endtask

    // Apply inputs, compare outputs mid-cycle, then advance model at the edge.
    task automatic cyc(input bit run, input int num, input bit dir, input bit rep,
                       input bit pause, input bit abort, input bit rstn);
        logic [W-1:0] e_cnt;
        bit           e_valid;
        i_run     = run;
        i_num_cnt = num[W-1:0];
        i_dir     = dir;
        i_repeat  = rep;
        i_pause   = pause;
        i_abort   = abort;
        reset_n   = rstn;
        #2;
        e_cnt   = m_act ? (m_dir ? W'(m_n - 1 - m_pos) : W'(m_pos)) : '0;
        e_valid = m_act && !pause;
        check("idle",    32'(o_idle),      32'(!m_act && !m_done));
        check("running", 32'(o_running),   32'(m_act));
        check("done",    32'(o_done),      32'(m_done));
        check("cnt",     32'(o_cnt),       32'(e_cnt));
        check("valid",   32'(o_cnt_valid), 32'(e_valid));
        check("tc",      32'(o_cnt_tc),    32'(e_valid && (m_pos == m_n - 1)));
        if (o_done === 1'b1) done_seen++;
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 1'b0;
            end else if (!pause) begin
                if (m_pos == m_n - 1) begin
                    m_pos = 0;
                    if (!m_rep) begin
                        m_act  = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_pos++;
                end
            end
        end else if (run && (num % (1 << W)) != 0) begin
            m_act = 1'b1;
            m_pos = 0;
            m_n   = num % (1 << W);
            m_dir = dir;
            m_rep = rep;
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        done_seen = 0;
        i_run = 0; i_num_cnt = '0; i_dir = 0; i_repeat = 0; i_pause = 0; i_abort = 0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, checked while reset is still held
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle_cycles(2);

        // N=5 up
        cyc(1, 5, 0, 0, 0, 0, 1);
        idle_cycles(8);

        // N=3 down
        cyc(1, 3, 1, 0, 0, 0, 1);
        idle_cycles(6);

        // N=4 up, two pause cycles while count is 1
        cyc(1, 4, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        idle_cycles(7);

        // N=2 repeat, then abort: no done pulse expected
        done_seen = 0;
        cyc(1, 2, 0, 1, 0, 0, 1);
        idle_cycles(7);
        cyc(0, 0, 0, 0, 0, 1, 1);
        idle_cycles(3);
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Zero-length start is ignored
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle_cycles(2);

        // Full-width N=255, with a run re-pulse in the middle
        done_seen = 0;
        cyc(1, 255, 0, 0, 0, 0, 1);
        idle_cycles(100);
        cyc(1, 7, 1, 1, 0, 0, 1);
        idle_cycles(158);
        check("n255_one_done", 32'(done_seen), 32'd1);

        // Reset mid-run at count 3, then clean restart
        done_seen = 0;
        cyc(1, 8, 0, 0, 0, 0, 1);
        idle_cycles(3);
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle_cycles(2);
        check("reset_no_done", 32'(done_seen), 32'd0);
        cyc(1, 3, 0, 0, 0, 0, 1);
        idle_cycles(5);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int  num;
            bit  rstn;
            num  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 6));
            rstn = ($urandom_range(0, 199) != 0);
            cyc(($urandom_range(0, 3) == 0), num, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0), rstn);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
